interp_sequencer: RTL and testbench

INTERP_SEQUENCER -- requirements
Module: interp_sequencer

---
 rtl/interp_pkg.sv | 23 ++
 rtl/interp_addr_gen.sv | 48 ++++
 rtl/interp_sequencer.sv | 120 ++++++++++++
 tb/tb_interp_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/interp_pkg.sv
// Shared types and constants for the interpolation-filter feed sequencer.
// Latency: n/a (package). Backpressure: n/a.
// Holds the FSM state enum, filter padding/latency constants and default frame size.
package interp_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_HEIGHT = 16;
    localparam int PAD_LEFT   = 7;
    localparam int PAD_RIGHT  = 6;
    localparam int OUT_LAT    = 13;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    function automatic int max_len(input int w, input int h);
        return (w > h) ? w : h;
    endfunction

endpackage

// File: rtl/interp_addr_gen.sv
// Maps (direction, line, slot) to source read index and destination write index.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller freezes slot/line to stall.
module interp_addr_gen
    import interp_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int KW     = $clog2(max_len(WIDTH, HEIGHT) + PAD_LEFT + PAD_RIGHT),
    parameter int LW     = $clog2(max_len(WIDTH, HEIGHT) + 1),
    localparam int AW    = $clog2(WIDTH * HEIGHT)
) (
    input  logic          dir,
    input  logic [KW-1:0] slot,
    input  logic [LW-1:0] line,
    output logic [AW-1:0] rd_addr,
    output logic [AW-1:0] wr_addr
);

    localparam logic [KW-1:0] LEN_H = KW'(WIDTH);
    localparam logic [KW-1:0] LEN_V = KW'(HEIGHT);

    logic [KW-1:0] len;
    logic [KW-1:0] p;
    logic [KW-1:0] q;

    always_comb begin
        len = dir ? LEN_V : LEN_H;
        // Left and right borders replicate the first and last pixel of the line.
        if (slot < KW'(PAD_LEFT)) begin
            p = '0;
        end else if (slot < len + KW'(PAD_LEFT)) begin
            p = slot - KW'(PAD_LEFT);
        end else begin
            p = len - KW'(1);
        end
        q = (slot >= KW'(OUT_LAT)) ? slot - KW'(OUT_LAT) : '0;

        if (dir) begin
            rd_addr = AW'(p) * AW'(WIDTH) + AW'(line);
            wr_addr = AW'(q) * AW'(WIDTH) + AW'(line);
        end else begin
            rd_addr = AW'(line) * AW'(WIDTH) + AW'(p);
            wr_addr = AW'(line) * AW'(WIDTH) + AW'(q);
        end
    end

endmodule

// File: rtl/interp_sequencer.sv
// Sequences one full-frame pass of reads into the interpolation filter and write-back strobes.
// Latency: rd_en/rd_addr combinational from counters; feed_valid/wr_en/wr_addr one cycle later.
// Backpressure: hold freezes slot issue in RUN; the pass resumes at the same slot.
module interp_sequencer
    import interp_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    localparam int AW    = $clog2(WIDTH * HEIGHT)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          pass_dir,
    input  logic          hold,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          feed_valid,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          busy,
    output logic          done
);

    localparam int LMAX = max_len(WIDTH, HEIGHT);
    localparam int KW   = $clog2(LMAX + PAD_LEFT + PAD_RIGHT);
    localparam int LW   = $clog2(LMAX + 1);

    state_t        state, state_nxt;
    logic [KW-1:0] slot, slot_nxt;
    logic [LW-1:0] line, line_nxt;
    logic          dir_q, dir_nxt;
    logic [KW-1:0] last_slot;
    logic [LW-1:0] last_line;
    logic          wr_en_nxt;
    logic [AW-1:0] wr_addr_c;

    assign last_slot = dir_q ? KW'(HEIGHT + PAD_LEFT + PAD_RIGHT - 1)
                             : KW'(WIDTH + PAD_LEFT + PAD_RIGHT - 1);
    assign last_line = dir_q ? LW'(WIDTH - 1) : LW'(HEIGHT - 1);

    always_comb begin
        state_nxt = state;
        slot_nxt  = slot;
        line_nxt  = line;
        dir_nxt   = dir_q;
        rd_en     = 1'b0;
        busy      = (state != IDLE);
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    dir_nxt   = pass_dir;
                    slot_nxt  = '0;
                    line_nxt  = '0;
                end
            end
            RUN: begin
                if (!hold) begin
                    rd_en = 1'b1;
                    if (slot == last_slot) begin
                        slot_nxt = '0;
                        if (line == last_line) begin
                            line_nxt  = '0;
                            state_nxt = DRAIN;
                        end else begin
                            line_nxt = line + LW'(1);
                        end
                    end else begin
                        slot_nxt = slot + KW'(1);
                    end
                end
            end
            DRAIN: state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Only slots past the filter's fill latency produce results.
    assign wr_en_nxt = rd_en && (slot >= KW'(OUT_LAT));

    interp_addr_gen #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .KW     (KW),
        .LW     (LW)
    ) u_addr_gen (
        .dir     (dir_q),
        .slot    (slot),
        .line    (line),
        .rd_addr (rd_addr),
        .wr_addr (wr_addr_c)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            slot       <= '0;
            line       <= '0;
            dir_q      <= 1'b0;
            feed_valid <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
        end else begin
            state      <= state_nxt;
            slot       <= slot_nxt;
            line       <= line_nxt;
            dir_q      <= dir_nxt;
            feed_valid <= rd_en;
            wr_en      <= wr_en_nxt;
            wr_addr    <= wr_addr_c;
        end
    end

endmodule

// File: tb/tb_interp_sequencer.sv
// Bench for interp_sequencer: directed passes plus randomized hold/start traffic vs a slot-count model.
module tb_interp_sequencer;

    localparam int W  = 16;
    localparam int H  = 16;
    localparam int AW = $clog2(W * H);

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          pass_dir;
    logic          hold;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          feed_valid;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          busy;
    logic          done;

    interp_sequencer #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .pass_dir   (pass_dir),
        .hold       (hold),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .feed_valid (feed_valid),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: a pass is just a count of issued slots out of a total.
    bit m_active;
    bit m_dir;
    bit m_prev_rd;
    int m_issued;
    int m_after;
    int m_prev_idx;

    int rel;
    int wr_cnt, fv_cnt, done_cnt, done_rel, hold_stalls, first_wr;
    bit seen [W*H];

    function automatic int line_len(input bit d);
        return d ? H : W;
    endfunction

    function automatic int line_cnt(input bit d);
        return d ? W : H;
    endfunction

    function automatic int slot_addr(input bit d, input int idx, input bit wr);
        int per, ln, k, pos;
        per = line_len(d) + 13;
        ln  = idx / per;
        k   = idx % per;
        if (wr)                     pos = k - 13;
        else if (k < 7)             pos = 0;
        else if (k < line_len(d)+7) pos = k - 7;
        else                        pos = line_len(d) - 1;
        return d ? pos * W + ln : ln * W + pos;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic st, input logic hd, input logic dr, input logic rs);
        bit e_rd, e_done, e_wr;
        int total, per;
        start    = st;
        hold     = hd;
        pass_dir = dr;
        reset    = rs;
        #1;
        per    = line_len(m_dir) + 13;
        total  = line_cnt(m_dir) * per;
        e_rd   = m_active && (m_issued < total) && !hd;
        e_done = m_active && (m_issued == total) && (m_after == 1);
        e_wr   = m_prev_rd && ((m_prev_idx % per) >= 13);
        chk("rd_en", rd_en, e_rd);
        if (e_rd) chk("rd_addr", rd_addr, slot_addr(m_dir, m_issued, 1'b0));
        chk("feed_valid", feed_valid, m_prev_rd);
        chk("wr_en", wr_en, e_wr);
        if (e_wr) chk("wr_addr", wr_addr, slot_addr(m_dir, m_prev_idx, 1'b1));
        chk("busy", busy, m_active);
        chk("done", done, e_done);

        if (wr_en === 1'b1) begin
            wr_cnt++;
            seen[wr_addr] = 1'b1;
            if (first_wr < 0) first_wr = rel;
        end
        if (feed_valid === 1'b1) fv_cnt++;
        if (done === 1'b1) begin
            done_cnt++;
            done_rel = rel;
        end
        if (m_active && (m_issued < total) && hd) hold_stalls++;

        m_prev_rd  = e_rd;
        m_prev_idx = m_issued;
        if (rs) begin
            m_active  = 1'b0;
            m_prev_rd = 1'b0;
            m_issued  = 0;
            m_after   = 0;
        end else if (!m_active) begin
            if (st) begin
                m_active = 1'b1;
                m_dir    = dr;
                m_issued = 0;
                m_after  = 0;
            end
        end else if (m_issued < total) begin
            if (!hd) m_issued++;
        end else begin
            m_after++;
            if (m_after == 2) m_active = 1'b0;
        end
        @(posedge clock);
        #1;
        rel++;
    endtask

    // mode 0: clean pass, 1: 5-cycle hold at line 3 slot 10, 2: ignored mid-pass starts,
    // 3: reset at cycle 100, 4: random holds and spurious starts.
    task automatic run_pass(input bit d, input int mode);
        logic st, hd, dr, rs;
        int   uniq;
        wr_cnt = 0; fv_cnt = 0; done_cnt = 0; done_rel = -1; hold_stalls = 0; first_wr = -1;
        foreach (seen[i]) seen[i] = 1'b0;
        rel = 0;
        do begin
            st = (rel == 0);
            dr = (rel == 0) ? d : 1'($urandom);
            hd = 1'b0;
            rs = 1'b0;
            case (mode)
                1: hd = (rel >= 98 && rel < 103);
                2: if (rel == 50 || rel == 200) begin st = 1'b1; dr = ~d; end
                3: rs = (rel == 100);
                4: begin
                    hd = ($urandom_range(0, 7) == 0);
                    if (rel > 0 && $urandom_range(0, 49) == 0) st = 1'b1;
                end
                default: ;
            endcase
            if (mode == 1 && rel == 103) chk("resume_addr", rd_addr, 51);
            tick(st, hd, dr, rs);
        end while (m_active && rel < 2000);

        if (m_active) chk("pass_timeout", 1, 0);

        if (mode == 3) begin
            chk("rst_rd_addr", rd_addr, 0);
            chk("rst_wr_addr", wr_addr, 0);
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            chk("rst_no_done", done_cnt, 0);
        end else begin
            uniq = 0;
            foreach (seen[i]) if (seen[i]) uniq++;
            chk("wr_count", wr_cnt, 256);
            chk("wr_unique", uniq, 256);
            chk("feed_count", fv_cnt, 464);
            chk("done_pulses", done_cnt, 1);
            chk("done_cycle", done_rel, 466 + hold_stalls);
            if (mode == 0) chk("first_wr_cycle", first_wr, 15);
            if (mode == 1) chk("hold_done_cycle", done_rel, 471);
        end
    endtask

    initial begin
        m_active = 1'b0; m_dir = 1'b0; m_prev_rd = 1'b0;
        m_issued = 0; m_after = 0; m_prev_idx = 0;
        reset = 1'b1; start = 1'b0; hold = 1'b0; pass_dir = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_rd_en", rd_en, 0);
        chk("reset_rd_addr", rd_addr, 0);
        chk("reset_feed_valid", feed_valid, 0);
        chk("reset_wr_en", wr_en, 0);
        chk("reset_wr_addr", wr_addr, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);

        run_pass(1'b0, 0);
        run_pass(1'b1, 0);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        run_pass(1'b0, 1);
        run_pass(1'b0, 2);
        run_pass(1'b0, 3);
        run_pass(1'b0, 0);
        for (int n = 0; n < 4; n++) begin
            tick(1'b0, 1'($urandom), 1'($urandom), 1'b0);
            run_pass(1'($urandom_range(0, 1)), 4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
